// File: rtl/seq_divider_hhrb98.sv
// Multi-cycle unsigned restoring divider: one quotient bit per enabled clock,
// with a divide-by-zero path that reports all-ones quotient and a flag.
module seq_divider_hhrb98 #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                state_r, state_nxt;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt;
  logic [DIVIDEND_W-1:0] dvd_r, dvd_nxt;
  logic [DIVISOR_W-1:0]  dvs_r, dvs_nxt;
  logic [DIVISOR_W:0]    pr_r, pr_nxt;
  logic [DIVIDEND_W-1:0] qw_r, qw_nxt;
  logic                  dz_pend_r, dz_pend_nxt;
  logic [DIVIDEND_W-1:0] quotient_r, quotient_nxt;
  logic [DIVISOR_W-1:0]  remainder_r, remainder_nxt;
  logic                  busy_r, busy_nxt;
  logic                  done_r, done_nxt;
  logic                  dbz_r, dbz_nxt;

  logic [DIVISOR_W:0]    pr_shift_s;
  logic                  fits_s;
  logic [DIVISOR_W:0]    pr_step_s;
  logic [DIVIDEND_W-1:0] q_step_s;
  logic                  accept_s;

  // One restoring step on the working registers, plus start acceptance.
  always_comb begin
    pr_shift_s = {pr_r[DIVISOR_W-1:0], dvd_r[DIVIDEND_W-1]};
    fits_s     = (pr_shift_s >= {1'b0, dvs_r});
    pr_step_s  = fits_s ? (pr_shift_s - {1'b0, dvs_r}) : pr_shift_s;
    q_step_s   = {qw_r[DIVIDEND_W-2:0], fits_s};
    accept_s   = ena && start &&
                 ((state_r == IDLE) || ((state_r == FIN) && !dz_pend_r));
  end

  // Next-state and next-register logic; everything holds while ena is low.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r;
    dvd_nxt       = dvd_r;
    dvs_nxt       = dvs_r;
    pr_nxt        = pr_r;
    qw_nxt        = qw_r;
    dz_pend_nxt   = dz_pend_r;
    quotient_nxt  = quotient_r;
    remainder_nxt = remainder_r;
    busy_nxt      = busy_r;
    done_nxt      = done_r;
    dbz_nxt       = dbz_r;
    if (!ena) begin
      state_nxt = state_r;
    end else if (accept_s) begin
      dvd_nxt  = dividend;
      dvs_nxt  = divisor;
      cnt_nxt  = CNT_W'(DIVIDEND_W);
      pr_nxt   = '0;
      qw_nxt   = '0;
      dbz_nxt  = 1'b0;
      done_nxt = 1'b0;
      // A zero divisor spends one FIN cycle preparing the flagged result.
      if (divisor == {DIVISOR_W{1'b0}}) begin
        state_nxt   = FIN;
        dz_pend_nxt = 1'b1;
        busy_nxt    = 1'b0;
      end else begin
        state_nxt   = CALC;
        dz_pend_nxt = 1'b0;
        busy_nxt    = 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          busy_nxt = 1'b0;
          done_nxt = 1'b0;
        end
        CALC: begin
          pr_nxt  = pr_step_s;
          qw_nxt  = q_step_s;
          dvd_nxt = {dvd_r[DIVIDEND_W-2:0], 1'b0};
          cnt_nxt = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_nxt     = FIN;
            quotient_nxt  = q_step_s;
            remainder_nxt = pr_step_s[DIVISOR_W-1:0];
            busy_nxt      = 1'b0;
            done_nxt      = 1'b1;
          end else begin
            state_nxt = CALC;
          end
        end
        FIN: begin
          if (dz_pend_r) begin
            dz_pend_nxt   = 1'b0;
            quotient_nxt  = '1;
            remainder_nxt = '0;
            dbz_nxt       = 1'b1;
            done_nxt      = 1'b1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
          end
        end
        default: begin
          state_nxt   = IDLE;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b0;
          dz_pend_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, working and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      pr_r        <= '0;
      qw_r        <= '0;
      dz_pend_r   <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      dvd_r       <= dvd_nxt;
      dvs_r       <= dvs_nxt;
      pr_r        <= pr_nxt;
      qw_r        <= qw_nxt;
      dz_pend_r   <= dz_pend_nxt;
      quotient_r  <= quotient_nxt;
      remainder_r <= remainder_nxt;
      busy_r      <= busy_nxt;
      done_r      <= done_nxt;
      dbz_r       <= dbz_nxt;
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider_hhrb98.sv
// Randomized self-checking bench for seq_divider_hhrb98 against plain
// integer division, including latency, abort, ignore and back-to-back cases.
module tb_seq_divider_hhrb98;

  logic       clk = 1'b0;
  logic       rst_n, ena, start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy, done, div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider_hhrb98 dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs clock edges until done, counting enabled edges and enabled busy cycles.
  task automatic wait_done(input bit rand_ena, output int en_edges,
                           output int busy_cyc, output bit seen);
    logic [7:0] q_hold;
    int guard;
    q_hold = quotient; en_edges = 0; busy_cyc = 0; seen = 1'b0; guard = 0;
    while (!seen && guard < 400) begin
      if (rand_ena) ena = ($urandom_range(0, 2) != 0);
      else ena = 1'b1;
      if (ena && busy) busy_cyc++;
      if (ena) en_edges++;
      tick();
      guard++;
      n_cmp++;
      if (busy && done) begin
        n_bad++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", busy, done);
      end
      if (busy && quotient !== q_hold) begin
        n_bad++;
        $display("FAIL quotient_hold: got %0d required %0d during calc", quotient, q_hold);
      end
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles", guard);
    end
    ena = 1'b1;
  endtask

  task automatic do_div(input logic [7:0] a, input logic [3:0] b, input bit rand_ena,
                        output logic [7:0] q, output logic [3:0] r, output logic dbz,
                        output int lat, output int busyc);
    bit seen;
    dividend = a; divisor = b; start = 1'b1; ena = 1'b1;
    tick();
    start = 1'b0;
    dividend = 8'($urandom); divisor = 4'($urandom);
    wait_done(rand_ena, lat, busyc, seen);
    q = quotient; r = remainder; dbz = div_by_zero;
    if (rand_ena) begin
      ena = 1'b0;
      tick();
      n_cmp++;
      if (done !== 1'b1) begin
        n_bad++;
        $display("FAIL done_frozen: got %0b required 1 with ena=0", done);
      end
      ena = 1'b1;
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_one_cycle: got %0b required 0", done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
    #1;
    n_cmp++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b required all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] q; logic [3:0] r; logic dbz; int lat, bc;
    do_div(8'd200, 4'd7, 1'b0, q, r, dbz, lat, bc);
    n_cmp++;
    if (q !== 8'd28 || r !== 4'd4 || dbz !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_200_7: got q=%0d r=%0d dbz=%0b required 28 4 0", q, r, dbz);
    end
    n_cmp++;
    if (lat !== 8 || bc !== 8) begin
      n_bad++;
      $display("FAIL basic_latency: got lat=%0d busy=%0d required 8 8", lat, bc);
    end
  endtask

  task automatic test_edges();
    logic [7:0] q; logic [3:0] r; logic dbz; int lat, bc;
    do_div(8'd255, 4'd1, 1'b0, q, r, dbz, lat, bc);
    n_cmp++;
    if (q !== 8'd255 || r !== 4'd0) begin
      n_bad++;
      $display("FAIL edge_255_1: got q=%0d r=%0d required 255 0", q, r);
    end
    do_div(8'd5, 4'd9, 1'b0, q, r, dbz, lat, bc);
    n_cmp++;
    if (q !== 8'd0 || r !== 4'd5) begin
      n_bad++;
      $display("FAIL edge_5_9: got q=%0d r=%0d required 0 5", q, r);
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q; logic [3:0] r; logic dbz; int lat, bc;
    do_div(8'h2D, 4'd0, 1'b0, q, r, dbz, lat, bc);
    n_cmp++;
    if (q !== 8'hFF || r !== 4'd0 || dbz !== 1'b1) begin
      n_bad++;
      $display("FAIL dz_result: got q=%0h r=%0d dbz=%0b required ff 0 1", q, r, dbz);
    end
    n_cmp++;
    if (lat !== 1 || bc !== 0) begin
      n_bad++;
      $display("FAIL dz_latency: got lat=%0d busy=%0d required 1 0", lat, bc);
    end
    do_div(8'd12, 4'd4, 1'b0, q, r, dbz, lat, bc);
    n_cmp++;
    if (q !== 8'd3 || r !== 4'd0 || dbz !== 1'b0) begin
      n_bad++;
      $display("FAIL dz_clear_12_4: got q=%0d r=%0d dbz=%0b required 3 0 0", q, r, dbz);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc; bit seen;
    dividend = 8'd100; divisor = 4'd3; start = 1'b1; ena = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dividend = 8'd50; divisor = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, lat, bc, seen);
    n_cmp++;
    if (quotient !== 8'd33 || remainder !== 4'd1 || lat + 2 !== 8) begin
      n_bad++;
      $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d required 33 1 8",
               quotient, remainder, lat + 2);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] q; logic [3:0] r; logic dbz; int lat, bc; int dones;
    dividend = 8'd225; divisor = 4'd15; start = 1'b1; ena = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0) begin
      n_bad++;
      $display("FAIL abort_reset: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b required all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    tick(); tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d done pulses required 0", dones);
    end
    do_div(8'd225, 4'd15, 1'b0, q, r, dbz, lat, bc);
    n_cmp++;
    if (q !== 8'd15 || r !== 4'd0) begin
      n_bad++;
      $display("FAIL abort_rerun: got q=%0d r=%0d required 15 0", q, r);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit seen;
    dividend = 8'd9; divisor = 4'd2; start = 1'b1; ena = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, lat, bc, seen);
    n_cmp++;
    if (quotient !== 8'd4 || remainder !== 4'd1) begin
      n_bad++;
      $display("FAIL b2b_first: got q=%0d r=%0d required 4 1", quotient, remainder);
    end
    dividend = 8'd144; divisor = 4'd12; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_reenter: got busy=%0b done=%0b required 1 0", busy, done);
    end
    wait_done(1'b0, lat, bc, seen);
    n_cmp++;
    if (quotient !== 8'd12 || remainder !== 4'd0 || lat !== 8) begin
      n_bad++;
      $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d required 12 0 8",
               quotient, remainder, lat);
    end
    tick();
  endtask

  task automatic test_sweep();
    logic [7:0] q; logic [3:0] r; logic dbz; int lat, bc;
    int ea, eb, exp_q, exp_r, exp_lat;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(8'(a), 4'(b), 1'b0, q, r, dbz, lat, bc);
        exp_q   = (b == 0) ? 255 : a / b;
        exp_r   = (b == 0) ? 0 : a % b;
        exp_lat = (b == 0) ? 1 : 8;
        n_cmp++;
        if (int'(q) != exp_q || int'(r) != exp_r || dbz !== (b == 0) || lat != exp_lat ||
            (b != 0 && (int'(q) * b + int'(r) != a || int'(r) >= b))) begin
          n_bad++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%0b lat=%0d required %0d %0d %0b %0d",
                   a, b, q, r, dbz, lat, exp_q, exp_r, (b == 0), exp_lat);
        end
      end
    end
    for (int k = 0; k < 150; k++) begin
      ea = $urandom_range(0, 255);
      eb = $urandom_range(0, 15);
      do_div(8'(ea), 4'(eb), 1'b1, q, r, dbz, lat, bc);
      exp_q   = (eb == 0) ? 255 : ea / eb;
      exp_r   = (eb == 0) ? 0 : ea % eb;
      exp_lat = (eb == 0) ? 1 : 8;
      n_cmp++;
      if (int'(q) != exp_q || int'(r) != exp_r || dbz !== (eb == 0) || lat != exp_lat) begin
        n_bad++;
        $display("FAIL ena_toggle %0d/%0d: got q=%0d r=%0d dbz=%0b lat=%0d required %0d %0d %0b %0d",
                 ea, eb, q, r, dbz, lat, exp_q, exp_r, (eb == 0), exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
